// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pll_lock_supervisor_if : PLL lock / domain-reset handshake signals     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface pll_lock_supervisor_if #(
    parameter int CW = 8
);
    logic          locked;
    logic          retry;
    logic          pll_resetb;
    logic          domain_reset;
    logic          ready;
    logic          fail;
    logic [CW-1:0] lock_loss_count;
    logic [2:0]    state;

    modport master (
        input  locked,
        input  retry,
        output pll_resetb,
        output domain_reset,
        output ready,
        output fail,
        output lock_loss_count,
        output state
    );

    modport slave (
        output locked,
        output retry,
        input  pll_resetb,
        input  domain_reset,
        input  ready,
        input  fail,
        input  lock_loss_count,
        input  state
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pll_lock_supervisor : sequences PLL RESETB, qualifies LOCK, gates the  |
// | PLL-domain reset; retries on timeout and latches FAIL. Rev 1.0        |
// +-----------------------------------------------------------------------+
module pll_lock_supervisor #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 4,
    parameter int CW            = 8
) (
    input  wire logic             clock_in,
    input  wire logic             reset,
    pll_lock_supervisor_if.master bus
);

    localparam int MAX_A   = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] C_RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] C_RETRY_MAX    = RTY_W'(MAX_RETRIES);
    localparam logic [CW-1:0]    C_LLC_MAX      = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retries_q, retries_d;
    logic [CW-1:0]    llc_q, llc_d;
    logic             sync1_q, locked_s_q;
    logic             pll_resetb_q, pll_resetb_d;
    logic             domain_reset_q, domain_reset_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             sync_clr;
    logic             counting;

    // The synchroniser is held cleared while the PLL is in reset so a stale
    // LOCK from a previous attempt can never qualify the new one.
    assign sync_clr = (state_q == ST_RESET_PLL) || (state_q == ST_FAIL);
    assign counting = (state_q == ST_RESET_PLL) || (state_q == ST_WAIT_LOCK) ||
                      (state_q == ST_STABLE);

    always_ff @(posedge clock_in) begin
        if (reset || sync_clr) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= bus.locked;
            locked_s_q <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        llc_d     = llc_q;
        case (state_q)
            ST_RESET_PLL: begin
                if (cnt_q == C_RESET_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == C_TIMEOUT_LAST) begin
                    retries_d = retries_q + RTY_W'(1);
                    state_d   = (retries_d == C_RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
                end
            end
            ST_STABLE: begin
                if (!locked_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (cnt_q == C_STABLE_LAST) begin
                    state_d   = ST_RUN;
                    retries_d = '0;
                end
            end
            ST_RUN: begin
                if (!locked_s_q) begin
                    state_d = ST_RESET_PLL;
                    if (llc_q != C_LLC_MAX) begin
                        llc_d = llc_q + CW'(1);
                    end
                end
            end
            ST_FAIL: begin
                if (bus.retry) begin
                    state_d   = ST_RESET_PLL;
                    retries_d = '0;
                end
            end
            default: begin
                state_d = ST_RESET_PLL;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (counting) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Outputs are decoded from the next state and registered with it.
    always_comb begin
        pll_resetb_d   = !((state_d == ST_RESET_PLL) || (state_d == ST_FAIL));
        domain_reset_d = (state_d != ST_RUN);
        ready_d        = (state_d == ST_RUN);
        fail_d         = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q        <= ST_RESET_PLL;
            cnt_q          <= '0;
            retries_q      <= '0;
            llc_q          <= '0;
            pll_resetb_q   <= 1'b0;
            domain_reset_q <= 1'b1;
            ready_q        <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            retries_q      <= retries_d;
            llc_q          <= llc_d;
            pll_resetb_q   <= pll_resetb_d;
            domain_reset_q <= domain_reset_d;
            ready_q        <= ready_d;
            fail_q         <= fail_d;
        end
    end

    assign bus.pll_resetb      = pll_resetb_q;
    assign bus.domain_reset    = domain_reset_q;
    assign bus.ready           = ready_q;
    assign bus.fail            = fail_q;
    assign bus.lock_loss_count = llc_q;
    assign bus.state           = state_q;

endmodule
`default_nettype wire

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the iCE40 SB_PLL40_CORE wrapper: drives its RESETB, watches its asynchronous LOCK output and gates the reset of the PLL-clocked domain.
- Runs on the 48 MHz reference clock, never on the PLL output.
- Retries the PLL on lock timeout, counts lock losses, and latches a fail flag after repeated timeouts.

Parameters:
- RESET_CYCLES, 16: cycles RESETB is held low per PLL reset attempt (>=1).
- LOCK_TIMEOUT, 4800: cycles allowed from RESETB release to first synchronised lock (100 us at 48 MHz, >=2).
- STABLE_CYCLES, 256: consecutive synchronised-lock cycles required before release (>=1).
- MAX_RETRIES, 4: consecutive lock timeouts before FAIL (>=1).
- CW, 8: width of lock_loss_count.

Ports:
- clock_in  input  1  reference clock, 48 MHz.
- reset  input  1  synchronous, active-high reset.
- locked  input  1  PLL LOCK; asynchronous to clock_in.
- retry  input  1  single-cycle pulse; leaves FAIL only.
- pll_resetb  output  1  to PLL RESETB; 0 holds the PLL in reset.
- domain_reset  output  1  reset for the PLL-clocked logic; 1 = held.
- ready  output  1  high only in RUN.
- fail  output  1  high only in FAIL.
- lock_loss_count  output  CW  saturating count of lock losses seen in RUN.
- state  output  3  encoding: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL.

Behaviour:
- Interface: one clock (clock_in); reset is synchronous and active-high.
- All outputs are registered and derive from the registered state.
- Reset: state=RESET_PLL, pll_resetb=0, domain_reset=1, ready=0, fail=0, lock_loss_count=0, cycle counter=0, retry counter=0, synchroniser=0. Reset mid-operation aborts any state identically.
- Synchroniser: 2-flop, locked -> s1 -> locked_s. Forced to 0 while in RESET_PLL or FAIL.
- Single cycle counter (width $clog2 of the largest of the three cycle parameters, plus 1). Cleared on every state change.
- RESET_PLL: pll_resetb=0, domain_reset=1. When count==RESET_CYCLES-1, go to WAIT_LOCK; pll_resetb=1 from that edge.
- WAIT_LOCK: pll_resetb=1.
  - locked_s=1: go to STABLE.
  - Otherwise, when count==LOCK_TIMEOUT-1: retries+1. If the new retries==MAX_RETRIES, go to FAIL; else go to RESET_PLL.
  - If locked_s goes high on the timeout cycle, the lock wins.
- STABLE:
  - locked_s=0: go to WAIT_LOCK with a fresh timeout; retries unchanged.
  - When count==STABLE_CYCLES-1 with locked_s=1: go to RUN, retries cleared.
- RUN: domain_reset=0, ready=1. locked_s=0: lock_loss_count+1 (saturates at 2^CW-1) and go to RESET_PLL. domain_reset=1 and ready=0 from the same edge.
- FAIL: pll_resetb=0, domain_reset=1, fail=1. On retry=1, go to RESET_PLL with retries cleared; lock_loss_count is kept.
- retry is ignored outside FAIL.
- Latency: locked first sampled 1 at edge k gives locked_s=1 after edge k+1, STABLE after edge k+2, and RUN/ready=1 after edge k+2+STABLE_CYCLES. Lock loss in RUN sampled at edge j gives domain_reset=1 after edge j+2.
- Glitch rule: a lock pulse shorter than STABLE_CYCLES never releases domain_reset.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, CW=2.
- Clean start: reset 3 cycles, then locked=1 fixed.
  - pll_resetb=0 for exactly 4 cycles after reset release.
  - ready=1 and domain_reset=0 exactly 2+8 cycles after the first edge sampling locked=1.
  - state sequence 0,1,2,3.
- Glitch: locked high for 5 cycles, low for 3, then high.
  - STABLE is aborted back to WAIT_LOCK.
  - ready rises only 10 cycles after the second rise.
  - lock_loss_count stays 0.
- Timeouts: locked held 0.
  - Two 20-cycle WAIT_LOCK windows separated by a 4-cycle RESET_PLL.
  - Then FAIL: fail=1, pll_resetb=0.
  - retry pulses before FAIL have no effect.
- Recover from FAIL: pulse retry with locked=1.
  - Goes RESET_PLL, WAIT_LOCK, STABLE, RUN.
  - fail=0 from the retry edge+1.
  - retries cleared, so a subsequent timeout sequence again needs two timeouts.
- Lock loss in RUN: drop locked 5 times, relocking each time.
  - domain_reset rises 2 edges after each drop.
  - lock_loss_count reads 1, 2, 3, 3, 3 (saturation).
- Reset mid-STABLE and mid-RUN:
  - Outputs return to reset values at the next edge.
  - lock_loss_count returns to 0.
